// File: rtl/port_extractor.sv
// Decodes one instruction word into the register-file port codes {unused, reg[4:0]}
// used for read A, read B and write; the three codes are registered together.
module port_extractor (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic [5:0]  readPortA,
  output logic [5:0]  readPortB,
  output logic [5:0]  writePort
);

  localparam logic [5:0] UNUSED = 6'b100000;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  logic [4:0] op, rd, rs, rt, aluop;
  logic [5:0] nextA, nextB, nextW;

  assign op    = instruction[31:27];
  assign rd    = instruction[26:22];
  assign rs    = instruction[21:17];
  assign rt    = instruction[16:12];
  assign aluop = instruction[6:2];

  // The all-zero word is a nop and overrides the opcode decode; $0 is otherwise an ordinary register.
  always_comb begin
    nextA = UNUSED;
    nextB = UNUSED;
    nextW = UNUSED;
    if (instruction != 32'h0) begin
      case (op)
        OP_RTYPE: begin
          case (aluop)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL, ALU_DIV: begin
              nextA = {1'b0, rs};
              nextB = {1'b0, rt};
              nextW = {1'b0, rd};
            end
            ALU_SLL, ALU_SRA: begin
              nextA = {1'b0, rs};
              nextW = {1'b0, rd};
            end
            default: ;
          endcase
        end
        OP_ADDI, OP_LW: begin
          nextA = {1'b0, rs};
          nextW = {1'b0, rd};
        end
        OP_SW, OP_BNE, OP_BLT: begin
          nextA = {1'b0, rs};
          nextB = {1'b0, rd};
        end
        OP_JR:   nextB = {1'b0, rd};
        OP_JAL:  nextW = {1'b0, 5'd31};
        OP_SETX: nextW = {1'b0, 5'd30};
        OP_J, OP_BEX: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readPortA <= UNUSED;
      readPortB <= UNUSED;
      writePort <= UNUSED;
    end else begin
      readPortA <= nextA;
      readPortB <= nextB;
      writePort <= nextW;
    end
  end

endmodule

// File: tb/tb_port_extractor.sv
// Table-driven scoreboard bench for port_extractor: each vector is driven on a falling
// edge, its expected codes queued, and checked just after the following rising edge.
module tb_port_extractor;

  logic        clock;
  logic        reset;
  logic [31:0] instruction;
  logic [5:0]  readPortA;
  logic [5:0]  readPortB;
  logic [5:0]  writePort;

  localparam logic [5:0] U = 6'b100000;

  typedef struct {
    string       name;
    logic        reset;
    logic [31:0] instruction;
    logic [5:0]  expA;
    logic [5:0]  expB;
    logic [5:0]  expW;
  } vector_t;

  vector_t vectors[$];
  vector_t scoreboard[$];
  int checkCount = 0;
  int failCount  = 0;

  port_extractor dut (
    .clock(clock),
    .reset(reset),
    .instruction(instruction),
    .readPortA(readPortA),
    .readPortB(readPortB),
    .writePort(writePort)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [5:0] p(input int r);
    logic [4:0] r5;
    r5 = r[4:0];
    return {1'b0, r5};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] shamt,
                                        input logic [4:0] aluop);
    return {5'b00000, rd, rs, rt, shamt, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic vector_t mk(input string name, input logic rst, input logic [31:0] ins,
                                 input logic [5:0] a, input logic [5:0] b, input logic [5:0] w);
    vector_t v;
    v.name = name; v.reset = rst; v.instruction = ins;
    v.expA = a; v.expB = b; v.expW = w;
    return v;
  endfunction

  task automatic compareOne(input string name, input logic [17:0] act, input logic [17:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got A=%b B=%b W=%b, expected A=%b B=%b W=%b",
               name, act[17:12], act[11:6], act[5:0], exp[17:12], exp[11:6], exp[5:0]);
    end
  endtask

  task automatic applyStimulus(input vector_t v);
    @(negedge clock);
    reset = v.reset;
    instruction = v.instruction;
    scoreboard.push_back(v);
  endtask

  task automatic checkOutput();
    vector_t e;
    forever begin
      @(posedge clock);
      #1;
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        compareOne(e.name, {readPortA, readPortB, writePort}, {e.expA, e.expB, e.expW});
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    instruction = 32'h0;

    vectors.push_back(mk("reset",        1'b1, 32'h00C22000, U, U, U));
    vectors.push_back(mk("add",          1'b0, 32'h00C22000, p(1), p(2), p(3)));
    vectors.push_back(mk("sub",          1'b0, 32'h02BD1004, p(30), p(17), p(10)));
    vectors.push_back(mk("sll",          1'b0, 32'h00C20090, p(1), U, p(3)));
    vectors.push_back(mk("div",          1'b0, 32'h00C2201C, p(1), p(2), p(3)));
    vectors.push_back(mk("and",          1'b0, rtype(5'd9, 5'd8, 5'd7, 5'd0, 5'b00010), p(8), p(7), p(9)));
    vectors.push_back(mk("or",           1'b0, rtype(5'd20, 5'd21, 5'd22, 5'd0, 5'b00011), p(21), p(22), p(20)));
    vectors.push_back(mk("mul",          1'b0, rtype(5'd31, 5'd16, 5'd15, 5'd0, 5'b00110), p(16), p(15), p(31)));
    vectors.push_back(mk("sra_shamt",    1'b0, rtype(5'd6, 5'd12, 5'd25, 5'd31, 5'b00101), p(12), U, p(6)));
    vectors.push_back(mk("bad_aluop",    1'b0, rtype(5'd6, 5'd12, 5'd25, 5'd0, 5'b01000), U, U, U));
    vectors.push_back(mk("add_r0_dest",  1'b0, 32'h00022000, p(1), p(2), p(0)));
    vectors.push_back(mk("addi",         1'b0, 32'h294E000A, p(7), U, p(5)));
    vectors.push_back(mk("addi_imm1s",   1'b0, itype(5'b00101, 5'd5, 5'd7, 17'h1FFFF), p(7), U, p(5)));
    vectors.push_back(mk("lw",           1'b0, 32'h4105FFFD, p(2), U, p(4)));
    vectors.push_back(mk("sw",           1'b0, 32'h3A960004, p(11), p(10), U));
    vectors.push_back(mk("bne",          1'b0, 32'h114E0003, p(7), p(5), U));
    vectors.push_back(mk("blt",          1'b0, itype(5'b00110, 5'd19, 5'd4, 17'h00123), p(4), p(19), U));
    vectors.push_back(mk("jr",           1'b0, 32'h20C00000, U, p(3), U));
    vectors.push_back(mk("jal",          1'b0, 32'h1800000F, U, U, p(31)));
    vectors.push_back(mk("setx",         1'b0, 32'hA800000F, U, U, p(30)));
    vectors.push_back(mk("bex",          1'b0, 32'hB000000F, U, U, U));
    vectors.push_back(mk("j",            1'b0, 32'h0800000F, U, U, U));
    vectors.push_back(mk("nop",          1'b0, 32'h00000000, U, U, U));
    vectors.push_back(mk("bad_opcode",   1'b0, itype(5'b11111, 5'd3, 5'd4, 17'h0F0F0), U, U, U));
    vectors.push_back(mk("sub_again",    1'b0, 32'h02BD1004, p(30), p(17), p(10)));
    vectors.push_back(mk("midreset",     1'b1, 32'h02BD1004, U, U, U));
    vectors.push_back(mk("after_reset",  1'b0, 32'h3A960004, p(11), p(10), U));

    fork
      checkOutput();
    join_none

    for (int i = 0; i < vectors.size(); i++) applyStimulus(vectors[i]);

    // Latency check: a newly driven word must not reach the outputs before the next edge.
    applyStimulus(mk("hold_sub",  1'b0, 32'h02BD1004, p(30), p(17), p(10)));
    applyStimulus(mk("to_jal",    1'b0, 32'h1800000F, U, U, p(31)));
    #1;
    compareOne("latency_before_edge", {readPortA, readPortB, writePort}, {p(30), p(17), p(10)});

    repeat (3) @(negedge clock);
    checkCount++;
    if (scoreboard.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", scoreboard.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
